// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides,
// a persistent NZCV flag register, and carry chaining from the stored C flag
// for multi-word arithmetic.
//
// Pipeline:
//   Stage 1 registers the accepted operation.
//   Stage 2 registers the computed y, nzcv and illegal outputs.
//
// Ports:
//   clk        in   1      Clock, rising edge.
//   rst_n      in   1      Asynchronous reset, active-low.
//   flush      in   1      Synchronous clear of the pipeline and the flag register.
//   in_valid   in   1      Operation presented.
//   in_ready   out  1      Stage 1 can accept an operation.
//   opcode     in   4      Operation code; encodings are defined in package alu_ops.
//   a, b       in   WIDTH  Operands. b[SHW-1:0] is the shift amount for shift ops.
//   cin        in   1      Carry/borrow in, used when use_cflag=0.
//   use_cflag  in   1      Use the stored C flag in place of cin.
//   set_flags  in   1      Commit this op's NZCV to the flag register.
//   out_valid  out  1      Result valid.
//   out_ready  in   1      Consumer accepts the result.
//   y          out  WIDTH  Result.
//   nzcv       out  4      Per-op flags {negative, zero, carry, overflow}.
//   illegal    out  1      Opcode is not one of the alu_ops encodings.
//   flags_q    out  4      Stored NZCV register.

package alu_ops;
  localparam logic [3:0] OP_ADD      = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_LL_SHIFT = 4'd2;
  localparam logic [3:0] OP_LR_SHIFT = 4'd3;
  localparam logic [3:0] OP_AL_SHIFT = 4'd4;
  localparam logic [3:0] OP_AR_SHIFT = 4'd5;
  localparam logic [3:0] OP_NOT      = 4'd6;
  localparam logic [3:0] OP_AND      = 4'd7;
  localparam logic [3:0] OP_OR       = 4'd8;
  localparam logic [3:0] OP_XOR      = 4'd9;
endpackage

module alu_pipe
  import alu_ops::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             use_cflag,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       nzcv,
  output logic             illegal,
  output logic [3:0]       flags_q
);

  localparam logic [SHW-1:0] SH_W = SHW'(WIDTH);

  // Stage 1 holding registers
  logic             s1_v;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic             s1_use_c;
  logic             s1_set;

  logic s2_free;
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_v || s2_free;

  // Stage 1 -> stage 2 datapath
  logic             ci;
  logic [SHW-1:0]   sh;
  logic             sh_big;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   sar;
  logic [WIDTH-1:0] res_y;
  logic             res_c;
  logic             res_v;
  logic             res_ill;
  logic [3:0]       res_nzcv;

  always_comb begin
    // flags_q is read live, so a chained op that directly follows a
    // set_flags op sees the carry committed on the previous edge.
    ci     = s1_use_c ? flags_q[1] : s1_cin;
    sh     = s1_b[SHW-1:0];
    sh_big = (sh >= SH_W);
    sum    = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, ci};
    // The top bit of the widened difference is set exactly when a < b + ci.
    diff   = {1'b0, s1_a} - {1'b0, s1_b} - {{WIDTH{1'b0}}, ci};
    // One guard bit beside the operand catches the last bit shifted out.
    // When sh = 0, the guard bit stays 0, which gives C = 0.
    shl    = {1'b0, s1_a} << sh;
    shr    = {s1_a, 1'b0} >> sh;
    sar    = $signed({s1_a, 1'b0}) >>> sh;

    res_y   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_y = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (res_y[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_y = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (res_y[WIDTH-1] != s1_a[WIDTH-1]);
      end
      // For an out-of-range amount, the logical shifts give y = 0 and C = 0.
      OP_LL_SHIFT, OP_AL_SHIFT: begin
        if (!sh_big) {res_c, res_y} = shl;
      end
      OP_LR_SHIFT: begin
        if (!sh_big) {res_y, res_c} = shr;
      end
      // For an out-of-range amount, the arithmetic shift saturates to the
      // sign bit, and the sign bit is also the last bit shifted out.
      OP_AR_SHIFT: begin
        if (!sh_big) begin
          {res_y, res_c} = sar;
        end else begin
          res_y = {WIDTH{s1_a[WIDTH-1]}};
          res_c = s1_a[WIDTH-1];
        end
      end
      OP_NOT: res_y = ~s1_a;
      OP_AND: res_y = s1_a & s1_b;
      OP_OR:  res_y = s1_a | s1_b;
      OP_XOR: res_y = s1_a ^ s1_b;
      default: res_ill = 1'b1;
    endcase
    res_nzcv = {res_y[WIDTH-1], (res_y == '0), res_c, res_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_cin    <= 1'b0;
      s1_use_c  <= 1'b0;
      s1_set    <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      nzcv      <= '0;
      illegal   <= 1'b0;
      flags_q   <= '0;
    end else if (flush) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      flags_q   <= '0;
    end else begin
      // in_ready with s1 occupied implies s2 is free, so s1 empties this edge.
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_op    <= opcode;
          s1_a     <= a;
          s1_b     <= b;
          s1_cin   <= cin;
          s1_use_c <= use_cflag;
          s1_set   <= set_flags;
        end
      end
      if (s2_free) begin
        out_valid <= s1_v;
        if (s1_v) begin
          y       <= res_y;
          nzcv    <= res_nzcv;
          illegal <= res_ill;
          if (s1_set) flags_q <= res_nzcv;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, self-checking bench for alu_pipe at WIDTH=4.
// Expected results are queued when an op is accepted. They are compared in
// order whenever out_valid is high, and popped when the result is consumed.
// Comparing on every valid cycle also checks that stalled outputs stay stable.

module tb_alu_pipe;
  import alu_ops::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         use_cflag;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   nzcv;
  logic         illegal;
  logic [3:0]   flags_q;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .use_cflag (use_cflag),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .nzcv      (nzcv),
    .illegal   (illegal),
    .flags_q   (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] ey;
    logic [3:0]   en;
    logic         ei;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. At the falling edge, check the current result against
  // the scoreboard and note whether the presented op will be accepted.
  // Then advance to 1ns after the rising edge.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && !flush && rst_n;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result observed y=%0h expected no result", y);
      end else begin
        check({sb[0].tag, ".y"},       y,       sb[0].ey);
        check({sb[0].tag, ".nzcv"},    nzcv,    sb[0].en);
        check({sb[0].tag, ".illegal"}, illegal, sb[0].ei);
        if (out_ready) void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic c, input logic uc, input logic sf);
    opcode    = op;
    a         = ta;
    b         = tb_;
    cin       = c;
    use_cflag = uc;
    set_flags = sf;
  endtask

  // Present one op and wait, with a bound, until it is accepted. in_valid
  // drops afterwards, so a following send() is back-to-back with no bubble.
  task automatic send(input string tag, input logic [3:0] op, input logic [W-1:0] ta,
                      input logic [W-1:0] tb_, input logic c, input logic uc, input logic sf,
                      input logic [W-1:0] ey, input logic [3:0] en, input logic ei);
    bit acc;
    acc = 1'b0;
    drive(op, ta, tb_, c, uc, sf);
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(acc);
      if (acc) break;
    end
    in_valid = 1'b0;
    if (acc) begin
      sb.push_back('{tag, ey, en, ei});
    end else begin
      checks++;
      errors++;
      $error("FAIL %s.accept observed=not accepted expected=accepted within 40 cycles", tag);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      step(acc);
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Stall stimulus: four ADDs, y = a + 2
  logic [W-1:0] st_a [4];
  logic [W-1:0] st_y [4];

  initial begin
    bit acc;
    int idx;
    st_a = '{4'd1, 4'd2, 4'd3, 4'd4};
    st_y = '{4'd3, 4'd4, 4'd5, 4'd6};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(4'd0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_flags_q",   flags_q,   0);
    check("rst_y",         y,         0);
    check("rst_nzcv",      nzcv,      0);
    check("rst_illegal",   illegal,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Latency: accepted at edge N, so out_valid rises after edge N+1
    send("not", OP_NOT, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1000, 1'b0);
    check("lat_n", out_valid, 0);
    step(acc);
    check("lat_n1", out_valid, 1);
    drain();

    // Carry chain, back-to-back
    send("add_c", OP_ADD, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0110, 1'b0);
    send("add_chain", OP_ADD, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
    drain();
    check("flags_after_add", flags_q, 4'b0110);

    // Subtract with borrow
    send("sub1", OP_SUB, 4'b1000, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0001, 1'b0);
    send("sub2", OP_SUB, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b1110, 4'b1010, 1'b0);
    send("sub_chain", OP_SUB, 4'b0101, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0);
    drain();
    check("flags_after_sub", flags_q, 4'b1010);

    // Shifts, including sh = 0 and sh >= WIDTH
    send("ar1", OP_AR_SHIFT, 4'b1001, 4'd1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b1010, 1'b0);
    send("ar5", OP_AR_SHIFT, 4'b1001, 4'd5, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1010, 1'b0);
    send("ll4", OP_LL_SHIFT, 4'b0001, 4'd4, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0);
    send("lr2", OP_LR_SHIFT, 4'b0110, 4'd2, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010, 1'b0);
    send("al1", OP_AL_SHIFT, 4'b0011, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0);
    send("ll0", OP_LL_SHIFT, 4'b1001, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1000, 1'b0);

    // Logic ops, and signed overflow on ADD
    send("and", OP_AND, 4'b1100, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0);
    send("or",  OP_OR,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0);
    send("xor", OP_XOR, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1000, 1'b0);
    send("add_v", OP_ADD, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1001, 1'b0);

    // Illegal opcode still updates the flag register
    send("illegal", 4'hF, 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b1);
    drain();
    check("flags_after_illegal", flags_q, 4'b0100);

    // Backpressure: only two ops are accepted while out_ready = 0
    out_ready = 1'b0;
    idx = 0;
    drive(OP_ADD, st_a[0], 4'd2, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(acc);
      if (acc) begin
        sb.push_back('{$sformatf("stall%0d", idx), st_y[idx], 4'b0000, 1'b0});
        idx++;
        if (idx < 4) drive(OP_ADD, st_a[idx], 4'd2, 1'b0, 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
    end
    check("stall_accepts",   idx,       2);
    check("stall_in_ready",  in_ready,  0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      step(acc);
      if (acc) begin
        sb.push_back('{$sformatf("stall%0d", idx), st_y[idx], 4'b0000, 1'b0});
        idx++;
        if (idx < 4) drive(OP_ADD, st_a[idx], 4'd2, 1'b0, 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stall_all_accepted", idx, 4);
    drain();

    // Asynchronous reset mid-stream, asserted between clock edges
    out_ready = 1'b0;
    send("pre_rst", OP_SUB, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b1110, 4'b1010, 1'b0);
    step(acc);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_flags", flags_q, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_flags", flags_q,   0);
    check("async_rst_y",     y,         0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Flush with both stages full and a new op presented
    out_ready = 1'b0;
    send("fl_a", OP_ADD, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0110, 1'b0);
    send("fl_b", OP_XOR, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0);
    check("pre_flush_flags", flags_q, 4'b0110);
    drive(OP_OR, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    flush = 1'b1;
    step(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_flags",     flags_q,   0);
    check("flush_in_ready",  in_ready,  1);
    out_ready = 1'b1;
    step(acc);
    check("flush_dropped", out_valid, 0);
    send("post_flush", OP_ADD, 4'b0010, 4'b0011, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
